frame_capture: RTL and testbench

FRAME_CAPTURE -- requirements
Module: frame_capture

---
 rtl/frame_pkg.sv | 9 +
 rtl/frame_capture_ram.sv | 30 +++
 rtl/frame_capture.sv | 73 +++++++
 tb/tb_frame_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: default frame geometry, capture FSM states and address-width helper
package frame_pkg;
  localparam int DEF_WIDTH = 128;
  localparam int DEF_HEIGHT = 128;
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/frame_capture_ram.sv
// frame_ram: byte-wide frame store, one sync write port and one registered read-before-write read port
module frame_ram
  import frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid
);
  logic [7:0] mem [DEPTH];
  // storage is never reset so a captured frame survives rst
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/frame_capture.sv
// frame_capture: captures one WIDTH x HEIGHT frame of pixels into RAM; optional checksum via CAPTURE_CHECKSUM_EN
module frame_capture
  import frame_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  localparam int ADDR_W = addr_w(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              valid_in,
  input  logic [7:0]        pixel_in,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);
  localparam int CW = addr_w(WIDTH);
  localparam int RW = addr_w(HEIGHT);
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic arm, we, last_col, last;
  logic [ADDR_W-1:0] wr_addr;
  always_comb begin
    arm = (state != CAPTURE) && start;
    we = (state == CAPTURE) && valid_in && !rst;
    last_col = col == CW'(WIDTH - 1);
    last = last_col && (row == RW'(HEIGHT - 1));
    wr_addr = ADDR_W'(int'(row) * WIDTH + int'(col));
    state_nx = arm ? CAPTURE : (we && last) ? DONE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= state_nx == CAPTURE;
      frame_done <= we && last;
      if (arm) begin
        col <= '0;
        row <= '0;
        overflow <= 1'b0;
      end else if (we) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= row + 1'b1;
      end else if (state == DONE && valid_in) begin
        overflow <= 1'b1;
      end
    end
`ifdef CAPTURE_CHECKSUM_EN
  always_ff @(posedge clk)
    if (rst || arm) checksum <= '0;
    else if (we) checksum <= checksum + 16'(pixel_in);
`endif
  frame_ram #(.DEPTH(WIDTH * HEIGHT), .AW(ADDR_W)) u_ram (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(pixel_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed bench for a 4x3 frame_capture with a read-data scoreboard
module tb_frame_capture;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int AW = $clog2(N);
  logic clk = 0, rst = 1, start = 0, valid_in = 0, rd_en = 0;
  logic [7:0] pixel_in = 0;
  logic [AW-1:0] rd_addr = 0;
  logic busy, frame_done, overflow, rd_valid;
  logic [7:0] rd_data;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int checks = 0, errors = 0, fd_count = 0;
  logic [7:0] exp_mem [N];
  logic [7:0] sb [$];

  frame_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .pixel_in(pixel_in),
    .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
`ifdef CAPTURE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // monitor: every rd_valid must match the oldest outstanding read request
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding, rd_data=%h", rd_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] v);
    valid_in = 1;
    pixel_in = v;
    step();
    valid_in = 0;
  endtask

  task automatic rd(input int a);
    rd_en = 1;
    rd_addr = AW'(a);
    sb.push_back(exp_mem[a]);
    step();
    rd_en = 0;
  endtask

  task automatic arm();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) rd(i);
    step();
  endtask

  // full frame of base+i; checks the frame_done pulse and busy drop on the last pixel
  task automatic frame(input logic [7:0] base, input bit gaps);
    int fd0;
    fd0 = fd_count;
    arm();
    check("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      pix(base + 8'(i));
      exp_mem[i] = base + 8'(i);
      if (i == N - 1) begin
        check("frame_done_pulse", frame_done, 1);
        check("busy_drop", busy, 0);
      end else if (gaps) step();
    end
    step();
    check("frame_done_single", frame_done, 0);
    check("frame_done_count", fd_count - fd0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int fd0;
    repeat (2) step();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    pix(8'h99);
    check("idle_valid_no_overflow", overflow, 0);
    check("idle_valid_busy", busy, 0);
    frame(8'h00, 0);
    read_all();
    check("rd_data_hold", rd_data, 8'h0B);
    frame(8'h10, 1);
    read_all();
    pix(8'hFF);
    pix(8'hFF);
    check("overflow_set", overflow, 1);
    rd(0);
    rd(1);
    step();
    start = 1;
    valid_in = 1;
    pixel_in = 8'hEE;
    step();
    start = 0;
    valid_in = 0;
    check("overflow_cleared", overflow, 0);
    check("restart_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      pix(8'h30 + 8'(i));
      exp_mem[i] = 8'h30 + 8'(i);
    end
    fd0 = fd_count;
    rst = 1;
    step();
    rst = 0;
    check("rst_mid_busy", busy, 0);
    repeat (3) step();
    check("rst_mid_no_done", fd_count - fd0, 0);
    rd(0);
    rd(4);
    frame(8'h20, 0);
    read_all();
    frame(8'h00, 0);
    arm();
    for (int i = 0; i < 3; i++) pix(8'(i));
    valid_in = 1;
    pixel_in = 8'h55;
    rd_en = 1;
    rd_addr = AW'(3);
    sb.push_back(8'h03);
    step();
    valid_in = 0;
    rd_en = 0;
    exp_mem[3] = 8'h55;
    for (int i = 4; i < N; i++) pix(8'(i));
    check("rbw_frame_done", frame_done, 1);
    rd(3);
    step();
    check("rbw_new_value", rd_data, 8'h55);
`ifdef CAPTURE_CHECKSUM_EN
    arm();
    for (int i = 0; i < N; i++) pix(8'hFF);
    check("checksum", checksum, 16'h0BF4);
    step();
`endif
    repeat (2) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
